// File: rtl/seq_match_pkg.sv
// seq_match_pkg
//   Shared types and reset-default configuration for the serial pattern
//   detector controller (seq_match_ctrl) and its matcher sub-block.
//   Contents:
//     state_e        - controller FSM states (S_IDLE, S_SHIFT)
//     DEF_PATTERN    - reset pattern (binary 1011, first expected bit is bit 3)
//     DEF_LEN        - reset pattern length (4)
//     DEF_OVERLAP    - reset overlap mode (non-overlapping)
//     DEF_THRESHOLD  - reset IRQ threshold (0 = IRQ disabled)
package seq_match_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    // Defaults are kept 32 bits wide and cut down to the configured
    // widths where they are loaded.
    localparam logic [31:0] DEF_PATTERN   = 32'h0000_000B;
    localparam int unsigned DEF_LEN       = 4;
    localparam logic        DEF_OVERLAP   = 1'b0;
    localparam logic [31:0] DEF_THRESHOLD = 32'd0;

endpackage

// File: rtl/pattern_matcher.sv
// pattern_matcher
//   Serial Moore-style pattern detector. Consumes one bit per clock when
//   bit_valid is high, keeps the recent bit history and a saturating count of
//   bits seen since the last (non-overlapping) match, and produces:
//     hit   - combinational: the bit being consumed this cycle completes a match
//     match - registered one-cycle pulse, high in the cycle after the
//             consuming edge
//   Ports:
//     clk, rst          - clock, synchronous active-high reset
//     clear             - synchronous clear of history/seen (config reload)
//     bit_valid, bit_in - serial input bit and its qualifier
//     pattern, len      - active pattern (pattern[len-1] is first bit), length
//     overlap           - 1 keeps the seen count after a match
import seq_match_pkg::*;

module pattern_matcher #(
    parameter  int MAX_PAT = 8,
    localparam int LEN_W   = $clog2(MAX_PAT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               bit_valid,
    input  logic               bit_in,
    input  logic [MAX_PAT-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit,
    output logic               match
);

    // Only MAX_PAT-1 bits of history are stored: the newest bit comes
    // straight from bit_in, so the oldest bit of a MAX_PAT-long window is
    // always the top stored bit and nothing older is ever compared.
    logic [MAX_PAT-2:0] hist_q, hist_d;
    logic [MAX_PAT-1:0] hist_n;
    logic [MAX_PAT-1:0] len_mask;
    logic [LEN_W-1:0]   seen_q, seen_d, seen_n;
    logic               match_q, match_d;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_PAT; i++) begin
            len_mask[i] = (i < int'(len));
        end

        hist_n = {hist_q, bit_in};
        seen_n = (seen_q >= len) ? len : seen_q + 1'b1;

        hit = bit_valid && (len != '0) && (seen_n == len) &&
              (((hist_n ^ pattern) & len_mask) == '0);

        hist_d  = hist_q;
        seen_d  = seen_q;
        match_d = 1'b0;

        if (clear) begin
            hist_d = '0;
            seen_d = '0;
        end else if (bit_valid) begin
            hist_d  = hist_n[MAX_PAT-2:0];
            // Non-overlapping mode restarts the window after a match.
            seen_d  = (hit && !overlap) ? '0 : seen_n;
            match_d = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= '0;
            seen_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            seen_q  <= seen_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl
//   Word-to-bit sequencing controller. Accepts DATA_W-bit words over a
//   valid/ready handshake, shifts them MSB-first one bit per clock into
//   pattern_matcher, counts matches (saturating) and raises a sticky IRQ when
//   the count reaches a programmable threshold.
//   Ports:
//     clk, rst            - clock, synchronous active-high reset
//     cfg_we              - config write strobe (honoured only when idle and
//                           no word is accepted in the same cycle)
//     cfg_pattern/len     - pattern and length (0 disables, >MAX_PAT clamps)
//     cfg_overlap         - overlapping detection enable
//     cfg_threshold       - IRQ threshold (0 disables IRQ)
//     in_valid, in_data   - producer word
//     in_ready            - word can be accepted this cycle
//     busy                - a word is being shifted
//     match_pulse         - one-cycle pulse per detected match
//     match_count         - saturating match counter
//     irq, irq_clr        - sticky threshold interrupt and its clear
import seq_match_pkg::*;

module seq_match_ctrl #(
    parameter  int DATA_W  = 8,
    parameter  int MAX_PAT = 8,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = $clog2(MAX_PAT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_PAT-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_threshold,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               busy,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic               irq,
    input  logic               irq_clr
);

    localparam int IDX_W = $clog2(DATA_W);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l > LEN_W'(MAX_PAT)) begin
            return LEN_W'(MAX_PAT);
        end
        return l;
    endfunction

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]   word_q, word_d;

    logic [MAX_PAT-1:0]  pattern_q, pattern_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                overlap_q, overlap_d;
    logic [CNT_W-1:0]    thr_q, thr_d;

    logic [CNT_W-1:0]    count_q, count_d, count_inc;
    logic                irq_q, irq_d;

    logic                accept;
    logic                cfg_accept;
    logic                bit_valid;
    logic                bit_in;
    logic                hit;

    // Ready on the last bit of a word as well, so back-to-back words
    // stream without an idle cycle between them.
    assign in_ready   = (state_q == S_IDLE) ||
                        ((state_q == S_SHIFT) && (bit_idx_q == '0));
    assign accept     = in_valid && in_ready;
    assign cfg_accept = cfg_we && (state_q == S_IDLE) && !accept;
    assign bit_valid  = (state_q == S_SHIFT);
    assign bit_in     = word_q[bit_idx_q];

    // FSM, word latch and bit index
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        word_d    = word_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_SHIFT;
                    word_d    = in_data;
                    bit_idx_d = IDX_W'(DATA_W - 1);
                end
            end
            S_SHIFT: begin
                if (bit_idx_q == '0) begin
                    if (accept) begin
                        word_d    = in_data;
                        bit_idx_d = IDX_W'(DATA_W - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Configuration registers
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        thr_d     = thr_q;
        if (cfg_accept) begin
            pattern_d = cfg_pattern;
            len_d     = clamp_len(cfg_len);
            overlap_d = cfg_overlap;
            thr_d     = cfg_threshold;
        end
    end

    // Match counter and sticky IRQ; counter and IRQ move on the same edge
    // that registers match_pulse, so they use the matcher's early hit.
    always_comb begin
        count_inc = count_q + 1'b1;
        count_d   = count_q;
        irq_d     = irq_q;

        if (cfg_accept) begin
            count_d = '0;
            irq_d   = 1'b0;
        end else begin
            if (irq_clr) begin
                irq_d = 1'b0;
            end
            // A saturated counter does not increment, so it cannot re-fire IRQ.
            if (hit && (count_q != '1)) begin
                count_d = count_inc;
                if ((thr_q != '0) && (count_inc == thr_q)) begin
                    irq_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
            word_q    <= '0;
            pattern_q <= MAX_PAT'(DEF_PATTERN);
            len_q     <= clamp_len(LEN_W'(DEF_LEN));
            overlap_q <= DEF_OVERLAP;
            thr_q     <= CNT_W'(DEF_THRESHOLD);
            count_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            word_q    <= word_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            thr_q     <= thr_d;
            count_q   <= count_d;
            irq_q     <= irq_d;
        end
    end

    pattern_matcher #(
        .MAX_PAT (MAX_PAT)
    ) u_matcher (
        .clk       (clk),
        .rst       (rst),
        .clear     (cfg_accept),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .pattern   (pattern_q),
        .len       (len_q),
        .overlap   (overlap_q),
        .hit       (hit),
        .match     (match_pulse)
    );

    assign busy        = (state_q == S_SHIFT);
    assign match_count = count_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
module tb_seq_match_ctrl;

    localparam int DATA_W  = 8;
    localparam int MAX_PAT = 8;
    localparam int CNT_W   = 3;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [MAX_PAT-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_threshold;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_ready;
    logic               busy;
    logic               match_pulse;
    logic [CNT_W-1:0]   match_count;
    logic               irq;
    logic               irq_clr;

    always #5 clk = ~clk;

    seq_match_ctrl #(
        .DATA_W  (DATA_W),
        .MAX_PAT (MAX_PAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_overlap   (cfg_overlap),
        .cfg_threshold (cfg_threshold),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .busy          (busy),
        .match_pulse   (match_pulse),
        .match_count   (match_count),
        .irq           (irq),
        .irq_clr       (irq_clr)
    );

    typedef struct {
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic [2:0] thr;
        logic [7:0] data;
        logic [7:0] emask;  // bit (7-k) set when bit k of the word produces a pulse
        logic [2:0] ecnt;
        logic       eirq;
    } vec_t;

    vec_t vecs[10];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len,
                             input logic ov, input logic [2:0] thr);
        cfg_pattern   = pat;
        cfg_len       = len;
        cfg_overlap   = ov;
        cfg_threshold = thr;
        cfg_we        = 1'b1;
        tick();
        cfg_we        = 1'b0;
    endtask

    task automatic send_word(input string name, input logic [7:0] d, output logic [7:0] mask);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        mask = '0;
        for (int k = 0; k < DATA_W; k++) begin
            tick();
            mask[DATA_W-1-k] = match_pulse;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  mask;
        logic [31:0] pulses;
        int          busy_cnt;

        vecs[0] = '{8'h0B, 4'd4,  1'b0, 3'd0, 8'hB0, 8'h10, 3'd1, 1'b0};
        vecs[1] = '{8'h05, 4'd3,  1'b1, 3'd0, 8'hAA, 8'h2A, 3'd3, 1'b0};
        vecs[2] = '{8'h05, 4'd3,  1'b0, 3'd0, 8'hAA, 8'h22, 3'd2, 1'b0};
        vecs[3] = '{8'h01, 4'd1,  1'b0, 3'd2, 8'h81, 8'h81, 3'd2, 1'b1};
        vecs[4] = '{8'hFF, 4'd0,  1'b0, 3'd1, 8'hFF, 8'h00, 3'd0, 1'b0};
        vecs[5] = '{8'h00, 4'd0,  1'b1, 3'd1, 8'h00, 8'h00, 3'd0, 1'b0};
        vecs[6] = '{8'hA5, 4'd15, 1'b0, 3'd0, 8'hA5, 8'h01, 3'd1, 1'b0};
        vecs[7] = '{8'hA5, 4'd8,  1'b0, 3'd0, 8'h5A, 8'h00, 3'd0, 1'b0};
        vecs[8] = '{8'h01, 4'd1,  1'b0, 3'd1, 8'h40, 8'h40, 3'd1, 1'b1};
        vecs[9] = '{8'h01, 4'd1,  1'b0, 3'd0, 8'hFF, 8'hFF, 3'd7, 1'b0};

        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; cfg_threshold = '0; in_valid = 1'b0;
        in_data = '0; irq_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulse", 32'(match_pulse), 32'd0);
        check("rst_count", 32'(match_count), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);

        // Reset-default pattern 1011 against 0xB0
        send_word("dflt", 8'hB0, mask);
        check("dflt_mask", 32'(mask), 32'h10);
        check("dflt_count", 32'(match_count), 32'd1);
        check("dflt_irq", 32'(irq), 32'd0);

        // Back-to-back words 0x01, 0x60 with a match spanning the boundary
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h01;
        tick();
        in_data  = 8'h60;
        pulses   = '0;
        busy_cnt = 0;
        for (int j = 1; j <= 17; j++) begin
            tick();
            if (match_pulse) pulses[j] = 1'b1;
            if (busy) busy_cnt++;
            if (j == 7) check("b2b_ready_bit0", 32'(in_ready), 32'd1);
            if (j == 8) begin
                check("b2b_busy_no_bubble", 32'(busy), 32'd1);
                in_valid = 1'b0;
            end
        end
        check("b2b_pulses", pulses, 32'h0000_0800);
        check("b2b_busy_cycles", 32'(busy_cnt), 32'd15);
        check("b2b_count", 32'(match_count), 32'd1);

        // Table-driven configurations
        for (int v = 0; v < 10; v++) begin
            cfg_write(vecs[v].pat, vecs[v].len, vecs[v].ov, vecs[v].thr);
            send_word($sformatf("vec%0d", v), vecs[v].data, mask);
            check($sformatf("vec%0d_mask", v), 32'(mask), 32'(vecs[v].emask));
            check($sformatf("vec%0d_count", v), 32'(match_count), 32'(vecs[v].ecnt));
            check($sformatf("vec%0d_irq", v), 32'(irq), 32'(vecs[v].eirq));
        end

        // IRQ set and clear in the same cycle: set wins; clear alone clears
        cfg_write(8'h01, 4'd1, 1'b0, 3'd1);
        in_valid = 1'b1;
        in_data  = 8'h80;
        tick();
        in_valid = 1'b0;
        irq_clr  = 1'b1;
        tick();
        irq_clr  = 1'b0;
        check("setwins_irq", 32'(irq), 32'd1);
        check("setwins_pulse", 32'(match_pulse), 32'd1);
        check("setwins_count", 32'(match_count), 32'd1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("clr_irq", 32'(irq), 32'd0);
        repeat (7) tick();
        check("setwins_idle", 32'(busy), 32'd0);

        // Saturation: counter sticks at all-ones and cannot re-fire IRQ
        cfg_write(8'h01, 4'd1, 1'b0, 3'd7);
        send_word("sat1", 8'hFF, mask);
        check("sat1_mask", 32'(mask), 32'hFF);
        check("sat1_count", 32'(match_count), 32'd7);
        check("sat1_irq", 32'(irq), 32'd1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("sat_clr_irq", 32'(irq), 32'd0);
        send_word("sat2", 8'hFF, mask);
        check("sat2_mask", 32'(mask), 32'hFF);
        check("sat2_count", 32'(match_count), 32'd7);
        check("sat2_irq", 32'(irq), 32'd0);

        // cfg_we during acceptance and while busy is ignored
        cfg_write(8'h0B, 4'd4, 1'b0, 3'd0);
        cfg_pattern   = 8'h01;
        cfg_len       = 4'd1;
        cfg_threshold = 3'd1;
        cfg_we        = 1'b1;
        in_valid      = 1'b1;
        in_data       = 8'hB0;
        tick();
        in_valid = 1'b0;
        mask = '0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            mask[8-j] = match_pulse;
        end
        cfg_we = 1'b0;
        check("cfgbusy_mask", 32'(mask), 32'h10);
        check("cfgbusy_count", 32'(match_count), 32'd1);
        check("cfgbusy_irq", 32'(irq), 32'd0);

        // Reset in the middle of a word
        cfg_write(8'h01, 4'd1, 1'b0, 3'd0);
        in_valid = 1'b1;
        in_data  = 8'hB0;
        tick();
        in_valid = 1'b0;
        tick();
        check("midrst_prepulse", 32'(match_pulse), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pulse", 32'(match_pulse), 32'd0);
        check("midrst_count", 32'(match_count), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        pulses = '0;
        repeat (6) begin
            tick();
            pulses[0] = pulses[0] | match_pulse;
        end
        check("midrst_no_pulse", pulses, 32'd0);
        send_word("midrst_dflt", 8'hB0, mask);
        check("midrst_dflt_mask", 32'(mask), 32'h10);
        check("midrst_dflt_count", 32'(match_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
